// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus and rebuilds the hex digit shown
// on each anode position once its pattern has been stable for STABLE_CYCLES clocks.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    upd_stb,
  output logic [2:0]              upd_idx,
  output logic                    seg_err,
  output logic                    err_sticky
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [6:0]              seg_q, seg_p;
  logic [3:0]              zero_cnt;
  logic [2:0]              sel_idx;
  logic                    sel_valid;
  logic                    same;
  logic                    capture;
  logic [3:0]              dec_hex;
  logic                    dec_legal;
  logic                    dec_blank;

  // an_p/seg_p hold the previous registered sample for run-length comparison
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= '1;
      seg_q <= 7'b1111111;
      an_p  <= '1;
      seg_p <= 7'b1111111;
    end else begin
      an_q  <= an;
      seg_q <= {a, b, c, d, e, f, g};
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign sel_valid = (zero_cnt == 4'd1);
  assign same      = ({an_q, seg_q} == {an_p, seg_p});

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!sel_valid) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = TRACK;
          cnt_nxt   = CW'(1);
        end
        TRACK: begin
          if (!same) begin
            cnt_nxt = CW'(1);
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!same) begin
            state_nxt = TRACK;
            cnt_nxt   = CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dec_hex   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (seg_q)
      7'b0000001: dec_hex = 4'h0;
      7'b1001111: dec_hex = 4'h1;
      7'b0010010: dec_hex = 4'h2;
      7'b0000110: dec_hex = 4'h3;
      7'b1001100: dec_hex = 4'h4;
      7'b0100100: dec_hex = 4'h5;
      7'b0100000: dec_hex = 4'h6;
      7'b0001111: dec_hex = 4'h7;
      7'b0000000: dec_hex = 4'h8;
      7'b0001100: dec_hex = 4'h9;
      7'b0001000: dec_hex = 4'hA;
      7'b1100000: dec_hex = 4'hB;
      7'b0110001: dec_hex = 4'hC;
      7'b1000010: dec_hex = 4'hD;
      7'b0110000: dec_hex = 4'hE;
      7'b0111000: dec_hex = 4'hF;
      7'b1111111: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture writes only the selected position; the digit value survives blank/illegal
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      digit_valid <= '0;
      blank_mask  <= '0;
      upd_stb     <= 1'b0;
      upd_idx     <= '0;
      seg_err     <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      upd_stb <= 1'b0;
      seg_err <= 1'b0;
      if (capture) begin
        upd_stb <= 1'b1;
        upd_idx <= sel_idx;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_idx == 3'(i)) begin
            digit_valid[i] <= dec_legal;
            blank_mask[i]  <= dec_blank;
            if (dec_legal) digits[4*i +: 4] <= dec_hex;
          end
        end
        if (!dec_legal && !dec_blank) begin
          seg_err    <= 1'b1;
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives anode/segment patterns on the
// falling edge and samples outputs on the falling edge.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  blank_mask;
  logic        upd_stb;
  logic [2:0]  upd_idx;
  logic        seg_err;
  logic        err_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .an(an_i),
    .a(seg_i[6]), .b(seg_i[5]), .c(seg_i[4]), .d(seg_i[3]),
    .e(seg_i[2]), .f(seg_i[1]), .g(seg_i[0]),
    .digits(digits), .digit_valid(digit_valid), .blank_mask(blank_mask),
    .upd_stb(upd_stb), .upd_idx(upd_idx), .seg_err(seg_err), .err_sticky(err_sticky)
  );

  always @(posedge upd_stb) stb_cnt++;
  always @(posedge seg_err) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [7:0] an_v, input logic [6:0] seg_v, input int n);
    an_i  = an_v;
    seg_i = seg_v;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] seg_of(input int h);
    case (h)
      0: return 7'b0000001;   1: return 7'b1001111;
      2: return 7'b0010010;   3: return 7'b0000110;
      4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;
      8: return 7'b0000000;   9: return 7'b0001100;
      10: return 7'b0001000;  11: return 7'b1100000;
      12: return 7'b0110001;  13: return 7'b1000010;
      14: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  int s;
  logic [31:0] dig_snap;
  logic [7:0]  val_snap;

  initial begin
    reset = 1'b0;
    an_i  = 8'hFF;
    seg_i = 7'b1111111;
    repeat (3) @(negedge clk);
    chk("rst_digits", digits, 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_blank", 32'(blank_mask), 32'h0);
    chk("rst_flags", 32'({upd_stb, upd_idx, seg_err, err_sticky}), 32'h0);

    // 1: latency of exactly STABLE_CYCLES edges
    reset = 1'b1;
    s = stb_cnt;
    hold(8'hFE, 7'b0000110, 4);
    chk("t1_no_early", 32'(stb_cnt - s), 32'd0);
    @(negedge clk);
    chk("t1_stb", 32'(upd_stb), 32'd1);
    chk("t1_digit0", 32'(digits[3:0]), 32'h3);
    chk("t1_valid0", 32'(digit_valid[0]), 32'd1);
    chk("t1_idx", 32'(upd_idx), 32'd0);
    @(negedge clk);
    chk("t1_stb_width", 32'(upd_stb), 32'd0);

    // 2: a 3-cycle pattern must not be captured
    hold(8'hFB, 7'b0001000, 3);
    s = stb_cnt;
    hold(8'hFB, 7'b0110001, 6);
    chk("t2_one_capture", 32'(stb_cnt - s), 32'd1);
    chk("t2_digit2", 32'(digits[11:8]), 32'hC);
    chk("t2_valid2", 32'(digit_valid[2]), 32'd1);
    chk("t2_idx", 32'(upd_idx), 32'd2);

    // 3: two anodes low is ignored; blank pattern sets blank_mask
    s = stb_cnt;
    dig_snap = digits;
    val_snap = digit_valid;
    hold(8'hF3, 7'b0000000, 10);
    chk("t3_no_stb", 32'(stb_cnt - s), 32'd0);
    chk("t3_digits_kept", digits, dig_snap);
    chk("t3_valid_kept", 32'(digit_valid), 32'(val_snap));
    hold(8'hF7, 7'b1111111, 6);
    chk("t3_blank3", 32'(blank_mask[3]), 32'd1);
    chk("t3_valid3", 32'(digit_valid[3]), 32'd0);
    chk("t3_no_err", 32'(err_sticky), 32'd0);

    // 4: dash is illegal; old digit value survives
    hold(8'hEF, 7'b0100100, 6);
    chk("t4_digit4_pre", 32'(digits[19:16]), 32'h5);
    s = err_cnt;
    hold(8'hEF, 7'b1111110, 6);
    chk("t4_err_pulses", 32'(err_cnt - s), 32'd1);
    chk("t4_err_low", 32'(seg_err), 32'd0);
    chk("t4_sticky", 32'(err_sticky), 32'd1);
    chk("t4_valid4", 32'(digit_valid[4]), 32'd0);
    chk("t4_blank4", 32'(blank_mask[4]), 32'd0);
    chk("t4_digit4_kept", 32'(digits[19:16]), 32'h5);

    // 5: full scan, then hold without re-capture
    s = stb_cnt;
    for (int k = 0; k < 8; k++) hold(~(8'h01 << k), seg_of(k), 6);
    chk("t5_pulses", 32'(stb_cnt - s), 32'd8);
    chk("t5_digits", digits, 32'h76543210);
    chk("t5_valid", 32'(digit_valid), 32'hFF);
    chk("t5_blank", 32'(blank_mask), 32'h00);
    hold(8'h7F, seg_of(7), 20);
    chk("t5_no_extra", 32'(stb_cnt - s), 32'd8);
    for (int k = 0; k < 8; k++) hold(~(8'h01 << k), seg_of(8 + k), 6);
    chk("t5_digits_hi", digits, 32'hFEDCBA98);
    chk("t5_err_kept", 32'(err_sticky), 32'd1);

    // 6: reset mid-run clears at once; a full run is needed afterwards
    hold(8'h7F, 7'b1111111, 6);
    hold(8'hFE, 7'b0000000, 3);
    reset = 1'b0;
    #1;
    chk("t6_digits", digits, 32'h0);
    chk("t6_valid", 32'(digit_valid), 32'h0);
    chk("t6_blank", 32'(blank_mask), 32'h0);
    chk("t6_flags", 32'({upd_stb, upd_idx, seg_err, err_sticky}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    s = stb_cnt;
    repeat (4) @(negedge clk);
    chk("t6_no_early", 32'(stb_cnt - s), 32'd0);
    @(negedge clk);
    chk("t6_stb", 32'(upd_stb), 32'd1);
    chk("t6_digit0", 32'(digits[3:0]), 32'h8);
    chk("t6_valid0", 32'(digit_valid), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
